// File: rtl/step_move_ctrl_if.sv
// Command/status bundle between a motion sequencer and step_move_ctrl.
// Optional STEP_POS_TRACK_EN adds the signed absolute position output.
interface step_move_ctrl_if #(
  parameter int STEP_W = 16
`ifdef STEP_POS_TRACK_EN
  , parameter int POS_W = 32
`endif
);
  logic              start;
  logic              dir_cmd;
  logic [STEP_W-1:0] target_steps;
  logic              abort;
  logic              step_in;
  logic              en;
  logic              direction;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_done;
`ifdef STEP_POS_TRACK_EN
  logic signed [POS_W-1:0] position;

  modport master (output start, dir_cmd, target_steps, abort, step_in,
                  input  en, direction, busy, done, steps_done, position);
  modport slave  (input  start, dir_cmd, target_steps, abort, step_in,
                  output en, direction, busy, done, steps_done, position);
`else
  modport master (output start, dir_cmd, target_steps, abort, step_in,
                  input  en, direction, busy, done, steps_done);
  modport slave  (input  start, dir_cmd, target_steps, abort, step_in,
                  output en, direction, busy, done, steps_done);
`endif
endinterface

// File: rtl/step_move_ctrl.sv
// Move sequencer for the stepper pulse generator: direction setup, step counting, hold.
// Define STEP_POS_TRACK_EN to add signed absolute position tracking.
module step_move_ctrl #(
  parameter int STEP_W           = 16,
  parameter int DIR_SETUP_CYCLES = 100,
  parameter int HOLD_CYCLES      = 1000
`ifdef STEP_POS_TRACK_EN
  , parameter int POS_W          = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  step_move_ctrl_if.slave   bus
);

  localparam int CNT_MAX = (DIR_SETUP_CYCLES > HOLD_CYCLES) ? DIR_SETUP_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_HOLD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        sync_q, sync_d;
  logic              en_q, en_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [STEP_W-1:0] target_q, target_d;
  logic [STEP_W-1:0] steps_q, steps_d;
`ifdef STEP_POS_TRACK_EN
  logic signed [POS_W-1:0] pos_q, pos_d;
`endif

  logic              step_edge;
  logic              count_step;
  logic              hit_target;
  logic              accept;
  logic [STEP_W-1:0] step_inc;

  // sync_q[1:0] is the metastability pair; sync_q[2] is the previous value for edge detect
  assign sync_d     = {sync_q[1:0], bus.step_in};
  assign step_edge  = sync_q[1] & ~sync_q[2];
  assign count_step = (state_q == S_RUN) && step_edge;
  assign step_inc   = steps_q + STEP_W'(1);
  assign hit_target = count_step && (step_inc == target_q);
  assign accept     = (state_q == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sync_q   <= '0;
      en_q     <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      target_q <= '0;
      steps_q  <= '0;
`ifdef STEP_POS_TRACK_EN
      pos_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      en_q     <= en_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      target_q <= target_d;
      steps_q  <= steps_d;
`ifdef STEP_POS_TRACK_EN
      pos_q    <= pos_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) state_d = (bus.target_steps == '0) ? S_DONE : S_SETUP;
      end
      S_SETUP: begin
        if (bus.abort) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DIR_SETUP_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (bus.abort || hit_target) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // en follows the next state so it drops on the same edge the final step is counted
  always_comb begin
    en_d     = (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_DONE);
    dir_d    = dir_q;
    target_d = target_q;
    steps_d  = steps_q;
`ifdef STEP_POS_TRACK_EN
    pos_d    = pos_q;
`endif
    if (accept) begin
      dir_d    = bus.dir_cmd;
      target_d = bus.target_steps;
      steps_d  = '0;
    end
    if (count_step) begin
      steps_d = step_inc;
`ifdef STEP_POS_TRACK_EN
      pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
`endif
    end
  end

  assign bus.en         = en_q;
  assign bus.direction  = dir_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps_done = steps_q;
`ifdef STEP_POS_TRACK_EN
  assign bus.position   = pos_q;
`endif

endmodule
